// File: rtl/cp0_pkg.sv
// Shared types for the CP0 register file and its exception-request producer.
package cp0_pkg;

    typedef struct packed {
        logic        valid;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] extra;
        logic [31:0] pc;
        logic        delayslot;
    } except_req_t;

    typedef struct packed {
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] badvaddr;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] ebase;
    } cp0_regs_t;

endpackage

// File: rtl/cp0_regfile.sv
// CP0 architectural register file: commits exceptions/ERET, serves MFC0/MTC0, runs Count/Compare.
// Optional timer interrupt (Cause.TI into IP7) is enabled by defining CP0_TIMER_INT_EN.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID      = 32'h0001_8000,
    parameter logic [31:0] EBASE_RST = 32'h8000_0000,
    parameter logic [31:0] CONFIG0   = 32'h8000_0083
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  except_req_t except_req,
    input  logic [4:0]  raddr,
    input  logic [2:0]  rsel,
    output logic [31:0] rdata,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [2:0]  wsel,
    input  logic [31:0] wdata,
    output cp0_regs_t   cp0_regs,
    output logic [7:0]  interrupt_req
);

    localparam logic [7:0] SelBadVAddr = {5'd8, 3'd0};
    localparam logic [7:0] SelCount    = {5'd9, 3'd0};
    localparam logic [7:0] SelCompare  = {5'd11, 3'd0};
    localparam logic [7:0] SelStatus   = {5'd12, 3'd0};
    localparam logic [7:0] SelCause    = {5'd13, 3'd0};
    localparam logic [7:0] SelEpc      = {5'd14, 3'd0};
    localparam logic [7:0] SelPrid     = {5'd15, 3'd0};
    localparam logic [7:0] SelEbase    = {5'd15, 3'd1};
    localparam logic [7:0] SelConfig   = {5'd16, 3'd0};

    localparam logic [31:0] StatusWmask = 32'h0040_FF07;
    localparam logic [31:0] CauseWmask  = 32'h0080_0300;
    localparam logic [31:0] EbaseWmask  = 32'h3FFF_F000;

    cp0_regs_t regs_q, regs_d;
    logic      toggle_q, toggle_d;
    logic      exc, eret, wr_compare, ti_d;

    always_comb begin
        regs_d     = regs_q;
        toggle_d   = ~toggle_q;
        wr_compare = 1'b0;
        exc        = except_req.valid & ~except_req.eret;
        eret       = except_req.valid & except_req.eret;

        if (toggle_q) begin
            regs_d.count = regs_q.count + 32'd1;
        end

        // Exception/ERET owns the edge; a concurrent MTC0 is dropped entirely.
        if (exc) begin
            if (!regs_q.status[1]) begin
                regs_d.epc       = except_req.delayslot ? except_req.pc - 32'd4 : except_req.pc;
                regs_d.cause[31] = except_req.delayslot;
            end
            regs_d.status[1]  = 1'b1;
            regs_d.cause[6:2] = except_req.code;
            if (except_req.code inside {[5'd1:5'd5]}) begin
                regs_d.badvaddr = except_req.extra;
            end
        end else if (eret) begin
            if (regs_q.status[2]) begin
                regs_d.status[2] = 1'b0;
            end else begin
                regs_d.status[1] = 1'b0;
            end
        end else if (we) begin
            case ({waddr, wsel})
                SelCount: begin
                    regs_d.count = wdata;
                    toggle_d     = 1'b0;
                end
                SelCompare: begin
                    regs_d.compare = wdata;
                    wr_compare     = 1'b1;
                end
                SelStatus: regs_d.status = (regs_q.status & ~StatusWmask) | (wdata & StatusWmask);
                SelCause:  regs_d.cause  = (regs_q.cause & ~CauseWmask) | (wdata & CauseWmask);
                SelEpc:    regs_d.epc    = wdata;
                SelEbase:  regs_d.ebase  = (regs_q.ebase & ~EbaseWmask) | (wdata & EbaseWmask);
                default: ;
            endcase
        end

`ifdef CP0_TIMER_INT_EN
        ti_d = ~wr_compare & (regs_q.cause[30] |
               ((regs_d.count == regs_d.compare) && (regs_d.compare != 32'd0)));
`else
        ti_d = 1'b0;
`endif
        regs_d.cause[30] = ti_d;
        // IP7:2 sample the previous cycle's TI, giving a uniform one-cycle latency.
        regs_d.cause[15:10] = {hw_int[5] | regs_q.cause[30], hw_int[4:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q.status   <= 32'h0040_0000;
            regs_q.cause    <= '0;
            regs_q.epc      <= '0;
            regs_q.badvaddr <= '0;
            regs_q.count    <= '0;
            regs_q.compare  <= '0;
            regs_q.ebase    <= EBASE_RST;
            toggle_q        <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            toggle_q <= toggle_d;
        end
    end

    always_comb begin
        rdata = '0;
        case ({raddr, rsel})
            SelBadVAddr: rdata = regs_q.badvaddr;
            SelCount:    rdata = regs_q.count;
            SelCompare:  rdata = regs_q.compare;
            SelStatus:   rdata = regs_q.status;
            SelCause:    rdata = regs_q.cause;
            SelEpc:      rdata = regs_q.epc;
            SelPrid:     rdata = PRID;
            SelEbase:    rdata = regs_q.ebase;
            SelConfig:   rdata = CONFIG0;
            default:     rdata = '0;
        endcase
    end

    assign cp0_regs      = regs_q;
    assign interrupt_req = regs_q.cause[15:8] & regs_q.status[15:8];

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized and directed bench for cp0_regfile against a field-level behavioural model.
module tb_cp0_regfile;
    import cp0_pkg::*;

`ifdef CP0_TIMER_INT_EN
    localparam bit TimerEn = 1'b1;
`else
    localparam bit TimerEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    except_req_t except_req;
    logic [4:0]  raddr;
    logic [2:0]  rsel;
    logic [31:0] rdata;
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  wsel;
    logic [31:0] wdata;
    cp0_regs_t   cp0_regs;
    logic [7:0]  interrupt_req;

    int checks = 0;
    int errors = 0;

    cp0_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .hw_int       (hw_int),
        .except_req   (except_req),
        .raddr        (raddr),
        .rsel         (rsel),
        .rdata        (rdata),
        .we           (we),
        .waddr        (waddr),
        .wsel         (wsel),
        .wdata        (wdata),
        .cp0_regs     (cp0_regs),
        .interrupt_req(interrupt_req)
    );

    always #5 clk = ~clk;

    // Behavioural model: registers kept as architectural fields.
    bit          m_on = 1'b0;
    bit          m_bev, m_erl, m_exl, m_ie;
    logic [7:0]  m_im;
    bit          m_bd, m_ti, m_iv;
    logic [7:0]  m_ip;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bad, m_compare, m_ebase;
    logic [31:0] m_cbase;    // Count value at the last load
    int unsigned m_cyc;      // edges since the last load
    bit          m_ti_prev;
    logic [31:0] m_ncount;

    function automatic logic [31:0] m_count();
        return m_cbase + 32'(m_cyc / 2);
    endfunction

    function automatic logic [31:0] m_status();
        return {9'b0, m_bev, 6'b0, m_im, 5'b0, m_erl, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 6'b0, m_iv, 7'b0, m_ip, 1'b0, m_exc, 2'b0};
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] r, input logic [2:0] s);
        if (s == 3'd0) begin
            case (r)
                5'd8:    return m_bad;
                5'd9:    return m_count();
                5'd11:   return m_compare;
                5'd12:   return m_status();
                5'd13:   return m_cause();
                5'd14:   return m_epc;
                5'd15:   return 32'h0001_8000;
                5'd16:   return 32'h8000_0083;
                default: return 32'h0;
            endcase
        end
        if (s == 3'd1 && r == 5'd15) return m_ebase;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1;
            m_bev = 1'b1; m_erl = 1'b0; m_exl = 1'b0; m_ie = 1'b0; m_im = '0;
            m_bd = 1'b0; m_ti = 1'b0; m_iv = 1'b0; m_ip = '0; m_exc = '0;
            m_epc = '0; m_bad = '0; m_compare = '0; m_ebase = 32'h8000_0000;
            m_cbase = '0; m_cyc = 0;
        end else if (m_on) begin
            m_ti_prev = m_ti;
            m_cyc++;
            if (except_req.valid && !except_req.eret) begin
                if (!m_exl) begin
                    m_epc = except_req.delayslot ? except_req.pc - 32'd4 : except_req.pc;
                    m_bd  = except_req.delayslot;
                end
                m_exl = 1'b1;
                m_exc = except_req.code;
                if (except_req.code >= 5'd1 && except_req.code <= 5'd5) m_bad = except_req.extra;
            end else if (except_req.valid) begin
                if (m_erl) m_erl = 1'b0;
                else m_exl = 1'b0;
            end else if (we && wsel == 3'd0) begin
                case (waddr)
                    5'd9:  begin m_cbase = wdata; m_cyc = 0; end
                    5'd11: begin m_compare = wdata; m_ti = 1'b0; end
                    5'd12: begin
                        m_bev = wdata[22]; m_im = wdata[15:8];
                        m_erl = wdata[2]; m_exl = wdata[1]; m_ie = wdata[0];
                    end
                    5'd13: begin m_iv = wdata[23]; m_ip[1:0] = wdata[9:8]; end
                    5'd14: m_epc = wdata;
                    default: ;
                endcase
            end else if (we && wsel == 3'd1 && waddr == 5'd15) begin
                m_ebase = (m_ebase & ~32'h3FFF_F000) | (wdata & 32'h3FFF_F000);
            end
            m_ncount = m_count();
            if (!(we && !except_req.valid && waddr == 5'd11 && wsel == 3'd0) &&
                m_ncount == m_compare && m_compare != 0)
                m_ti = 1'b1;
            m_ti = m_ti & TimerEn;
            m_ip[7:2] = {hw_int[5] | m_ti_prev, hw_int[4:0]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_on) begin
            chk("status",   cp0_regs.status,   m_status());
            chk("cause",    cp0_regs.cause,    m_cause());
            chk("epc",      cp0_regs.epc,      m_epc);
            chk("badvaddr", cp0_regs.badvaddr, m_bad);
            chk("count",    cp0_regs.count,    m_count());
            chk("compare",  cp0_regs.compare,  m_compare);
            chk("ebase",    cp0_regs.ebase,    m_ebase);
            chk("rdata",    rdata,             m_rdata(raddr, rsel));
            chk("intreq",   {24'b0, interrupt_req}, {24'b0, m_ip & m_im});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 1'b0; hw_int = '0; except_req = '0;
        we = 1'b0; waddr = '0; wsel = '0; wdata = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        we = 1'b1; waddr = a; wsel = s; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                         input logic [31:0] extra, input logic is_eret);
        except_req.valid = 1'b1; except_req.eret = is_eret; except_req.code = code;
        except_req.pc = pc; except_req.delayslot = ds; except_req.extra = extra;
        tick();
        except_req = '0;
    endtask

    task automatic mfc0(input logic [4:0] a, input logic [2:0] s, input string name,
                        input logic [31:0] exp);
        raddr = a; rsel = s;
        #1;
        chk(name, rdata, exp);
    endtask

    logic [4:0] pick;

    initial begin
        clr();
        raddr = '0; rsel = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        chk("rst_status", cp0_regs.status, 32'h0040_0000);
        chk("rst_ebase",  cp0_regs.ebase,  32'h8000_0000);
        chk("rst_count",  cp0_regs.count,  32'h0);
        chk("rst_intreq", {24'b0, interrupt_req}, 32'h0);
        mfc0(5'd15, 3'd0, "mfc0_prid", 32'h0001_8000);
        mfc0(5'd15, 3'd1, "mfc0_ebase", 32'h8000_0000);
        mfc0(5'd16, 3'd0, "mfc0_config", 32'h8000_0083);
        mfc0(5'd3, 3'd0, "mfc0_unmapped", 32'h0);

        mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
        mfc0(5'd13, 3'd0, "cause_wmask", 32'h0080_0300);
        mtc0(5'd13, 3'd0, 32'h0);

        raise(5'd4, 32'hBFC0_0104, 1'b1, 32'h0000_0003, 1'b0);
        chk("ds_epc",    cp0_regs.epc,      32'hBFC0_0100);
        chk("ds_cause",  cp0_regs.cause,    32'h8000_0010);
        chk("ds_badva",  cp0_regs.badvaddr, 32'h0000_0003);
        chk("ds_status", cp0_regs.status,   32'h0040_0002);

        raise(5'd8, 32'h8000_1000, 1'b0, 32'h0, 1'b0);
        chk("nest_epc",   cp0_regs.epc,      32'hBFC0_0100);
        chk("nest_cause", cp0_regs.cause,    32'h8000_0020);
        chk("nest_badva", cp0_regs.badvaddr, 32'h0000_0003);
        raise(5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("eret_status", cp0_regs.status, 32'h0040_0000);

        we = 1'b1; waddr = 5'd12; wsel = 3'd0; wdata = 32'h0000_FF01;
        raise(5'd10, 32'h0000_2000, 1'b0, 32'h0, 1'b0);
        we = 1'b0;
        chk("conflict_status", cp0_regs.status, 32'h0040_0002);
        chk("conflict_epc",    cp0_regs.epc,    32'h0000_2000);
        chk("conflict_cause",  cp0_regs.cause,  32'h0000_0028);
        raise(5'd0, 32'h0, 1'b0, 32'h0, 1'b1);

        mtc0(5'd12, 3'd0, 32'h0000_8000);
        mtc0(5'd11, 3'd0, 32'd5);
        mtc0(5'd9, 3'd0, 32'd0);
        repeat (9) tick();
        chk("tmr_count4", cp0_regs.count, 32'd4);
        chk("tmr_ti_early", {31'b0, cp0_regs.cause[30]}, 32'd0);
        tick();
        chk("tmr_count5", cp0_regs.count, 32'd5);
        chk("tmr_ti", {31'b0, cp0_regs.cause[30]}, {31'b0, TimerEn});
        chk("tmr_ip7_lat", {31'b0, cp0_regs.cause[15]}, 32'd0);
        tick();
        chk("tmr_ip7", {31'b0, cp0_regs.cause[15]}, {31'b0, TimerEn});
        chk("tmr_intreq7", {31'b0, interrupt_req[7]}, {31'b0, TimerEn});
        mtc0(5'd11, 3'd0, 32'h100);
        chk("tmr_ti_clr", {31'b0, cp0_regs.cause[30]}, 32'd0);
        chk("tmr_ip7_hold", {31'b0, cp0_regs.cause[15]}, {31'b0, TimerEn});
        tick();
        chk("tmr_ip7_clr", {31'b0, cp0_regs.cause[15]}, 32'd0);

        mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
        chk("wrap_load", cp0_regs.count, 32'hFFFF_FFFF);
        tick();
        chk("wrap_hold", cp0_regs.count, 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", cp0_regs.count, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            except_req.valid     = ($urandom_range(0, 7) == 0);
            except_req.eret      = ($urandom_range(0, 2) == 0);
            except_req.code      = 5'($urandom);
            except_req.extra     = $urandom;
            except_req.pc        = $urandom;
            except_req.delayslot = 1'($urandom);
            we = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 8))
                0: pick = 5'd8;  1: pick = 5'd9;  2: pick = 5'd11; 3: pick = 5'd12;
                4: pick = 5'd13; 5: pick = 5'd14; 6: pick = 5'd15; 7: pick = 5'd16;
                default: pick = 5'($urandom);
            endcase
            waddr = pick;
            wsel  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            if (pick == 5'd15 && $urandom_range(0, 1) == 0) wsel = 3'd1;
            wdata = ((pick == 5'd9 || pick == 5'd11) && $urandom_range(0, 1) == 0) ?
                    32'($urandom_range(0, 24)) : $urandom;
            raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 16));
            rsel  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 1)) : 3'd0;
            tick();
        end
        clr();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
